div3_burst_ctrl: RTL and testbench

Sequencer for the divide-by-3 counter datapath: owns the 4-bit count register, steps it through `div3Comb` (0→1→2→0), and runs a programmable burst of N divide-by-3 periods on a start request. Emits a one-cycle `tick` per completed period, a `done` pulse at burst end, and a running period count. Sits between a host/control FSM and any logic that needs a clock-enable at f/3 for a bounded number of periods.

---
 rtl/div3_burst_ctrl_pkg.sv | 14 +
 rtl/div3_burst_ctrl_if.sv | 39 +++
 rtl/div3_burst_ctrl_div3comb.sv | 14 +
 rtl/div3_burst_ctrl.sv | 107 ++++++++++
 tb/tb_div3_burst_ctrl.sv | 134 +++++++++++++
 5 files changed

// File: rtl/div3_burst_ctrl_pkg.sv
// Shared types and constants for the divide-by-3 burst sequencer.
// Build option: DIV3_PAUSE_EN adds a pause input to the control interface.
package div3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_RST  = 4'h0;
  localparam logic [3:0] CNT_TERM = 4'h2;

endpackage

// File: rtl/div3_burst_ctrl_if.sv
// Control/observe bundle between a host FSM (master) and div3_burst_ctrl (slave).
// Build option: DIV3_PAUSE_EN adds the pause signal to both modports.
interface div3_burst_ctrl_if #(
  parameter int CNT_W = 8
);

  logic             start;
  logic             stop;
  logic [CNT_W-1:0] burst_len;
  logic             busy;
  logic             tick;
  logic             done;
  logic [CNT_W-1:0] tick_cnt;
  logic [3:0]       cnt;
`ifdef DIV3_PAUSE_EN
  logic             pause;

  modport master (
    output start, stop, burst_len, pause,
    input  busy, tick, done, tick_cnt, cnt
  );

  modport slave (
    input  start, stop, burst_len, pause,
    output busy, tick, done, tick_cnt, cnt
  );
`else
  modport master (
    output start, stop, burst_len,
    input  busy, tick, done, tick_cnt, cnt
  );

  modport slave (
    input  start, stop, burst_len,
    output busy, tick, done, tick_cnt, cnt
  );
`endif

endinterface

// File: rtl/div3_burst_ctrl_div3comb.sv
// Next-state logic of the divide-by-3 counter: 0 -> 1 -> 2 -> 0.
// Out-of-range counts simply increment; they never occur in normal operation.
module div3Comb
  import div3_pkg::*;
(
  input  logic [3:0] cnt,
  output logic [3:0] nxtCnt,
  output logic       three
);

  assign three  = (cnt == CNT_TERM);
  assign nxtCnt = three ? CNT_RST : cnt + 4'h1;

endmodule

// File: rtl/div3_burst_ctrl.sv
// Burst sequencer: runs burst_len divide-by-3 periods per start, ticking once per period.
// Build option: DIV3_PAUSE_EN enables the pause input (frozen counting while in RUN).
module div3_burst_ctrl
  import div3_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  div3_burst_ctrl_if.slave bus
);

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] tickCnt_q;
  logic             tick_q;
  logic             done_q;
  logic             busy_q;

  logic [3:0]       nxtCnt;
  logic             three;
  logic [CNT_W-1:0] tickInc;
  logic             pauseEn;

`ifdef DIV3_PAUSE_EN
  assign pauseEn = bus.pause;
`else
  assign pauseEn = 1'b0;
`endif

  assign tickInc = tickCnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  div3Comb u_div3Comb (
    .cnt    (cnt_q),
    .nxtCnt (nxtCnt),
    .three  (three)
  );

  // Every output is registered; tick and done fall back to zero unless set this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_RST;
      len_q     <= '0;
      tickCnt_q <= '0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q  <= CNT_RST;
          busy_q <= 1'b0;
          if (bus.start) begin
            len_q     <= bus.burst_len;
            tickCnt_q <= '0;
            busy_q    <= 1'b1;
            if (bus.burst_len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          // Abort wins over both pause and completion of the final period.
          if (bus.stop) begin
            state_q <= IDLE;
            cnt_q   <= CNT_RST;
            busy_q  <= 1'b0;
          end else if (!pauseEn) begin
            cnt_q <= nxtCnt;
            if (three) begin
              tick_q    <= 1'b1;
              tickCnt_q <= tickInc;
              if (tickInc == len_q) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          cnt_q   <= CNT_RST;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= CNT_RST;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.tick     = tick_q;
  assign bus.done     = done_q;
  assign bus.tick_cnt = tickCnt_q;
  assign bus.cnt      = cnt_q;

endmodule

// File: tb/tb_div3_burst_ctrl.sv
// Directed bench for div3_burst_ctrl; cycle 0 is the cycle whose closing edge samples start.
// Build option: DIV3_PAUSE_EN additionally exercises the pause input.
module tb_div3_burst_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   testsRun = 0;
  int   testsFailed = 0;

  div3_burst_ctrl_if #(.CNT_W(8)) bus ();

  div3_burst_ctrl #(.CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic startV, input logic stopV, input logic [7:0] lenV,
                               input logic pauseV);
    bus.start     = startV;
    bus.stop      = stopV;
    bus.burst_len = lenV;
`ifdef DIV3_PAUSE_EN
    bus.pause     = pauseV;
`else
    if (pauseV) $display("[TB] pause requested in a build without pause");
`endif
  endtask

  // Starts a burst in the current cycle and checks cycles 1..lastCycle against hand masks.
  task automatic runBurst(input string tag, input logic [7:0] len, input logic holdStart,
                          input int stopCycle, input logic [31:0] pauseMask, input int lastCycle,
                          input logic [31:0] expTick, input logic [31:0] expDone,
                          input logic [31:0] expBusy);
    int k;
    int expCnt;
    k = 0;
    applyStimulus(1'b1, 1'b0, len, 1'b0);
    for (int c = 1; c <= lastCycle; c++) begin
      nextCycle();
      applyStimulus(holdStart, c == stopCycle, len, pauseMask[c]);
      if (expTick[c]) k++;
      checkOutput($sformatf("%s.tick@%0d", tag, c), {31'b0, bus.tick}, {31'b0, expTick[c]});
      checkOutput($sformatf("%s.done@%0d", tag, c), {31'b0, bus.done}, {31'b0, expDone[c]});
      checkOutput($sformatf("%s.busy@%0d", tag, c), {31'b0, bus.busy}, {31'b0, expBusy[c]});
      checkOutput($sformatf("%s.tick_cnt@%0d", tag, c), {24'b0, bus.tick_cnt}, k);
      if (pauseMask == 32'b0) begin
        expCnt = expBusy[c] ? (c - 1) % 3 : 0;
        checkOutput($sformatf("%s.cnt@%0d", tag, c), {28'b0, bus.cnt}, expCnt);
      end else if (c >= 2 && c <= 5 && expBusy[c]) begin
        checkOutput($sformatf("%s.cntFrozen@%0d", tag, c), {28'b0, bus.cnt}, 32'd1);
      end
    end
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'd3, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("rst.busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("rst.tick", {31'b0, bus.tick}, 32'd0);
    checkOutput("rst.done", {31'b0, bus.done}, 32'd0);
    checkOutput("rst.tick_cnt", {24'b0, bus.tick_cnt}, 32'd0);
    checkOutput("rst.cnt", {28'b0, bus.cnt}, 32'd0);

    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd3, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("idle.busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("idle.cnt", {28'b0, bus.cnt}, 32'd0);

    // len=3: ticks 4,7,10; done 10; busy 1..10
    runBurst("len3", 8'd3, 1'b0, -1, 32'h0, 11, 32'h0490, 32'h0400, 32'h07FE);
    nextCycle();

    // len=0: done and busy in cycle 1 only
    runBurst("len0", 8'd0, 1'b0, -1, 32'h0, 3, 32'h0, 32'h0002, 32'h0002);
    nextCycle();

    // len=5 aborted in cycle 8, then len=1 restart
    runBurst("len5stop", 8'd5, 1'b0, 8, 32'h0, 9, 32'h0090, 32'h0, 32'h01FE);
    checkOutput("len5stop.holdCnt", {24'b0, bus.tick_cnt}, 32'd2);
    runBurst("len1", 8'd1, 1'b0, -1, 32'h0, 5, 32'h0010, 32'h0010, 32'h001E);
    nextCycle();

    // start held: second burst accepted in cycle 8 and aborted on its final-tick edge
    runBurst("hold1", 8'd2, 1'b1, -1, 32'h0, 8, 32'h0090, 32'h0080, 32'h00FE);
    runBurst("hold2", 8'd2, 1'b0, 6, 32'h0, 8, 32'h0010, 32'h0, 32'h007E);
    nextCycle();

    applyStimulus(1'b1, 1'b0, 8'd5, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'd5, 1'b0);
    for (int i = 0; i < 4; i++) nextCycle();
    checkOutput("midRst.pre", {24'b0, bus.tick_cnt}, 32'd1);
    rst_n = 1'b0;
    nextCycle();
    checkOutput("midRst.busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("midRst.tick_cnt", {24'b0, bus.tick_cnt}, 32'd0);
    checkOutput("midRst.cnt", {28'b0, bus.cnt}, 32'd0);
    rst_n = 1'b1;
    nextCycle();

`ifdef DIV3_PAUSE_EN
    // pause in cycles 2..4 shifts ticks to 7 and 10
    runBurst("pause", 8'd2, 1'b0, -1, 32'h001C, 11, 32'h0480, 32'h0400, 32'h07FE);
    nextCycle();
    runBurst("pauseStop", 8'd2, 1'b0, 3, 32'h000C, 5, 32'h0, 32'h0, 32'h000E);
    nextCycle();
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
